// File: rtl/decod_pkg.sv
// rtl/decod_pkg.sv - shared types, mode constants and one-hot helper for the decoder
package decod_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest select vector the helper can produce; callers narrow with a size cast.
    localparam int ONEHOT_MAX = 256;

    function automatic logic [ONEHOT_MAX-1:0] onehot(input int idx, input int outs);
        logic [ONEHOT_MAX-1:0] v;
        v = '0;
        if (idx >= 0 && idx < outs && idx < ONEHOT_MAX) begin
            v = ONEHOT_MAX'(1) << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/decod_dwell_cnt.sv
// rtl/decod_dwell_cnt.sv - loadable dwell down-counter with terminal-count flag
module decod_dwell_cnt #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               dec,
    output logic               tc
);

    logic [DWELL_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/decod_param_scan.sv
// rtl/decod_param_scan.sv - registered one-hot decoder with scan sequencer; DECOD_ERR_EN enables out-of-range err
module decod_param_scan
    import decod_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int OUTS    = 8,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel_in,
    input  logic               sel_valid,
    output logic               sel_ready,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUTS-1:0]    out,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               wrap,
    output logic               err
);

    state_t           state;
    logic             transfer;
    logic             cnt_tc;
    logic             cnt_clr;
    logic             cnt_load;
    logic             cnt_dec;
    logic [SEL_W-1:0] nxt_idx;

    assign sel_ready = en & (mode == MODE_DIRECT) & rst_n;
    assign transfer  = sel_valid & sel_ready;

    // Scan index never steps past OUTS-1, so codes >= OUTS are skipped.
    always_comb begin
        nxt_idx = cur_sel + 1'b1;
        if (int'(cur_sel) >= OUTS - 1) begin
            nxt_idx = '0;
        end
    end

    assign cnt_clr  = ~en;
    assign cnt_load = en & (mode == MODE_SCAN) & ((state != SCAN) | cnt_tc);
    assign cnt_dec  = en & (mode == MODE_SCAN) & (state == SCAN) & ~cnt_tc;

    decod_dwell_cnt #(
        .DWELL_W (DWELL_W)
    ) u_dwell_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (dwell),
        .dec      (cnt_dec),
        .tc       (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            out     <= '0;
            cur_sel <= '0;
            wrap    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (!en) begin
                state <= IDLE;
                out   <= '0;
            end else if (mode == MODE_SCAN) begin
                state <= SCAN;
                if (state != SCAN) begin
                    cur_sel <= '0;
                    out     <= OUTS'(onehot(0, OUTS));
                end else if (cnt_tc) begin
                    cur_sel <= nxt_idx;
                    out     <= OUTS'(onehot(int'(nxt_idx), OUTS));
                    wrap    <= (nxt_idx == '0);
                end
            end else begin
                state <= DIRECT;
                // An accepted code wins over the clear on leaving SCAN so no transfer is lost.
                if (transfer) begin
                    cur_sel <= sel_in;
                    out     <= OUTS'(onehot(int'(sel_in), OUTS));
                end else if (state == SCAN) begin
                    out <= '0;
                end
            end
        end
    end

`ifdef DECOD_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= transfer && (int'(sel_in) >= OUTS);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_decod_param_scan.sv
// tb/tb_decod_param_scan.sv - table-driven and sequence checks for decod_param_scan (SEL_W=3, OUTS=6)
module tb_decod_param_scan;

    localparam int SEL_W   = 3;
    localparam int OUTS    = 6;
    localparam int DWELL_W = 8;

`ifdef DECOD_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic               en;
    logic               mode;
    logic [SEL_W-1:0]   sel_in;
    logic               sel_valid;
    logic               sel_ready;
    logic [DWELL_W-1:0] dwell;
    logic [OUTS-1:0]    out;
    logic [SEL_W-1:0]   cur_sel;
    logic               wrap;
    logic               err;

    int n_vec;
    int n_fail;

    decod_param_scan #(
        .SEL_W   (SEL_W),
        .OUTS    (OUTS),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .sel_in    (sel_in),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .dwell     (dwell),
        .out       (out),
        .cur_sel   (cur_sel),
        .wrap      (wrap),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic               en;
        logic               mode;
        logic [SEL_W-1:0]   sel;
        logic               valid;
        logic [DWELL_W-1:0] dwell;
        logic               exp_ready;
        logic [OUTS-1:0]    exp_out;
        logic [SEL_W-1:0]   exp_cur;
        logic               exp_wrap;
        logic               exp_err;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_scan(input string name, input int idx, input logic exp_wrap);
        logic [OUTS-1:0] e;
        e = OUTS'(1) << idx;
        chk({name, ".out"}, 32'(out), 32'(e));
        chk({name, ".cur"}, 32'(cur_sel), 32'(idx));
        chk({name, ".wrap"}, 32'(wrap), 32'(exp_wrap));
    endtask

    initial begin
        int exp_b[8];
        n_vec  = 0;
        n_fail = 0;

        //            en    mode  sel   vld   dwell rdy   out          cur   wrap  err
        tbl[0]  = '{1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 1'b0, 6'b000000, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 3'd5, 1'b1, 8'd0, 1'b1, 6'b100000, 3'd5, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 3'd2, 1'b0, 8'd0, 1'b1, 6'b100000, 3'd5, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 3'd2, 1'b1, 8'd0, 1'b1, 6'b000100, 3'd2, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 3'd0, 1'b1, 8'd0, 1'b1, 6'b000001, 3'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 3'd7, 1'b1, 8'd0, 1'b1, 6'b000000, 3'd7, 1'b0, ERR_ON};
        tbl[6]  = '{1'b1, 1'b0, 3'd6, 1'b0, 8'd0, 1'b1, 6'b000000, 3'd7, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 3'd6, 1'b1, 8'd0, 1'b1, 6'b000000, 3'd6, 1'b0, ERR_ON};
        tbl[8]  = '{1'b1, 1'b0, 3'd3, 1'b1, 8'd0, 1'b1, 6'b001000, 3'd3, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 3'd1, 1'b1, 8'd2, 1'b0, 6'b000001, 3'd0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 3'd1, 1'b1, 8'd2, 1'b0, 6'b000001, 3'd0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 3'd1, 1'b0, 8'd2, 1'b0, 6'b000001, 3'd0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 3'd1, 1'b0, 8'd2, 1'b0, 6'b000010, 3'd1, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 3'd1, 1'b0, 8'd2, 1'b1, 6'b000000, 3'd1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 3'd1, 1'b0, 8'd2, 1'b0, 6'b000000, 3'd1, 1'b0, 1'b0};

        rst_n     = 1'b0;
        en        = 1'b1;
        mode      = 1'b0;
        sel_in    = '0;
        sel_valid = 1'b0;
        dwell     = '0;
        #12;
        chk("rst.out", 32'(out), 32'd0);
        chk("rst.cur", 32'(cur_sel), 32'd0);
        chk("rst.wrap", 32'(wrap), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.ready", 32'(sel_ready), 32'd0);
        step();
        en    = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            en        = tbl[i].en;
            mode      = tbl[i].mode;
            sel_in    = tbl[i].sel;
            sel_valid = tbl[i].valid;
            dwell     = tbl[i].dwell;
            #1;
            chk($sformatf("v%0d.ready", i), 32'(sel_ready), 32'(tbl[i].exp_ready));
            step();
            chk($sformatf("v%0d.out", i), 32'(out), 32'(tbl[i].exp_out));
            chk($sformatf("v%0d.cur", i), 32'(cur_sel), 32'(tbl[i].exp_cur));
            chk($sformatf("v%0d.wrap", i), 32'(wrap), 32'(tbl[i].exp_wrap));
            chk($sformatf("v%0d.err", i), 32'(err), 32'(tbl[i].exp_err));
        end

        // Full scan with dwell=2: three cycles per index, wrap on return to 0.
        sel_valid = 1'b0;
        en        = 1'b1;
        mode      = 1'b1;
        dwell     = 8'd2;
        for (int k = 0; k < 19; k++) begin
            step();
            chk_scan($sformatf("scanA%0d", k), (k / 3) % OUTS, k == 18);
        end

        // dwell=0 steps every cycle; raising dwell only stretches the following step.
        en = 1'b0;
        step();
        chk("scanB.idle", 32'(out), 32'd0);
        en    = 1'b1;
        dwell = 8'd0;
        exp_b = '{0, 1, 2, 3, 3, 3, 3, 4};
        for (int j = 0; j < 8; j++) begin
            if (j == 3) dwell = 8'd3;
            step();
            chk_scan($sformatf("scanB%0d", j), exp_b[j], 1'b0);
        end

        // Dropping en at index 2 clears out; re-enabling restarts at index 0.
        en = 1'b0;
        step();
        en    = 1'b1;
        dwell = 8'd0;
        for (int j = 0; j < 3; j++) begin
            step();
            chk_scan($sformatf("scanC%0d", j), j, 1'b0);
        end
        en = 1'b0;
        step();
        chk("scanC.drop.out", 32'(out), 32'd0);
        chk("scanC.drop.cur", 32'(cur_sel), 32'd2);
        en = 1'b1;
        step();
        chk_scan("scanC.restart", 0, 1'b0);

        // Asynchronous reset between edges mid-scan.
        step();
        chk_scan("scanD.pre", 1, 1'b0);
        #3;
        rst_n = 1'b0;
        mode  = 1'b0;
        #1;
        chk("arst.out", 32'(out), 32'd0);
        chk("arst.cur", 32'(cur_sel), 32'd0);
        chk("arst.wrap", 32'(wrap), 32'd0);
        chk("arst.ready", 32'(sel_ready), 32'd0);
        step();
        chk("arst.hold.out", 32'(out), 32'd0);
        chk("arst.hold.ready", 32'(sel_ready), 32'd0);
        rst_n = 1'b1;
        en    = 1'b0;
        step();
        chk("arst.idle.out", 32'(out), 32'd0);
        en        = 1'b1;
        sel_in    = 3'd4;
        sel_valid = 1'b1;
        step();
        chk("arst.direct.out", 32'(out), 32'b010000);
        chk("arst.direct.cur", 32'(cur_sel), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
